// File: rtl/csam_mul_arbiter.sv
//------------------------------------------------------------------------------
// Module   : csam_mul_arbiter
// Purpose  : Two-requester arbiter around one signed 8x4 carry-save array
//            multiplier. Optional per-requester accumulators: CSAM_MUL_ACC_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module csam_mul_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int RES_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][7:0]       req_x,
    input  logic [1:0][3:0]       req_y,
    input  logic [1:0]            req_acc,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_id,
    output logic [RES_W-1:0]      res_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic              r_id;
    logic [7:0]        r_x;
    logic [3:0]        r_y;
    logic              w_gnt;
    logic              w_gnt_id;
    logic [RES_W-1:0]  w_sext;
    logic [RES_W-1:0]  w_result;

    always_comb begin
        w_next    = r_state;
        w_gnt     = 1'b0;
        w_gnt_id  = 1'b0;
        req_ready = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (rst_n && (req_valid != 2'b00)) begin
                    w_gnt = 1'b1;
                    if (req_valid == 2'b11)
                        w_gnt_id = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
                    else
                        w_gnt_id = req_valid[1];
                    req_ready = w_gnt_id ? 2'b10 : 2'b01;
                    w_next    = S_MUL;
                end
            end
            S_MUL:   w_next = S_HOLD;
            S_HOLD:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Signed array multiply: Y bit 3 carries weight -8, so its row is subtracted.
    logic [11:0]       w_xe;
    logic [3:0][11:0]  w_pp;
    logic [11:0]       w_s;
    logic [11:0]       w_c;
    logic [11:0]       w_z;

    assign w_xe = {{4{r_x[7]}}, r_x};

    generate
        for (genvar j = 0; j < 4; j++) begin : g_pp
            assign w_pp[j] = r_y[j] ? (w_xe << j) : 12'd0;
        end
    endgenerate

    assign w_s    = w_pp[0] ^ w_pp[1] ^ w_pp[2];
    assign w_c    = ((w_pp[0] & w_pp[1]) | (w_pp[0] & w_pp[2]) | (w_pp[1] & w_pp[2])) << 1;
    assign w_z    = w_s + w_c + ~w_pp[3] + 12'd1;
    assign w_sext = RES_W'($signed(w_z));

`ifdef CSAM_MUL_ACC_EN
    logic                   r_acc_op;
    logic [1:0][RES_W-1:0]  r_acc;

    assign w_result = r_acc_op ? (r_acc[r_id] + w_sext) : w_sext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_op <= 1'b0;
            r_acc    <= '0;
        end else begin
            if (w_gnt)
                r_acc_op <= req_acc[w_gnt_id];
            if (r_state == S_MUL)
                r_acc[r_id] <= w_result;
        end
    end
`else
    logic w_unused_acc;
    assign w_unused_acc = ^req_acc;
    assign w_result     = w_sext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_x      <= 8'd0;
            r_y      <= 4'd0;
            res_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_gnt) begin
                r_last <= w_gnt_id;
                r_id   <= w_gnt_id;
                r_x    <= req_x[w_gnt_id];
                r_y    <= req_y[w_gnt_id];
            end
            if (r_state == S_MUL)
                res_data <= w_result;
        end
    end

    assign res_valid = (r_state == S_HOLD);
    assign busy      = (r_state != S_IDLE);
    assign res_id    = r_id;

endmodule

`default_nettype wire

// File: tb/tb_csam_mul_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_csam_mul_arbiter
// Purpose  : Scoreboard bench for csam_mul_arbiter (honours CSAM_MUL_ACC_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_csam_mul_arbiter;

    localparam int FIXED_PRIO = 0;
    localparam int RES_W      = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][7:0]   req_x;
    logic [1:0][3:0]   req_y;
    logic [1:0]        req_acc;
    logic              res_valid;
    logic              res_ready;
    logic              res_id;
    logic [RES_W-1:0]  res_data;
    logic              busy;

    always #5 clk = ~clk;

    csam_mul_arbiter #(.FIXED_PRIO(FIXED_PRIO), .RES_W(RES_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_acc(req_acc),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_data(res_data), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic             id;
        logic [RES_W-1:0] data;
    } exp_t;

    exp_t sb[$];

    // Reference model: one operation occupies the multiplier from acceptance
    // until its result is taken; the result is visible two cycles after acceptance.
    bit               m_busy;
    int               m_age;
    bit               m_last;
    logic [RES_W-1:0] m_acc [2];
    logic [1:0]       m_rdy;
    bit               m_g;
    bit               m_vld;
    exp_t             m_item;

    function automatic logic [RES_W-1:0] ref_product(input logic [7:0] x, input logic [3:0] y);
        int px;
        int py;
        px = $signed(x);
        py = $signed(y);
        return RES_W'(px * py);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_age    = 0;
            m_last   = 1'b1;
            m_acc[0] = '0;
            m_acc[1] = '0;
            sb.delete();
        end else begin
            m_vld = m_busy && (m_age >= 1);
            m_rdy = 2'b00;
            m_g   = 1'b0;
            if (!m_busy && (req_valid != 2'b00)) begin
                if (req_valid == 2'b11)
                    m_g = (FIXED_PRIO != 0) ? 1'b0 : !m_last;
                else
                    m_g = req_valid[1];
                m_rdy = m_g ? 2'b10 : 2'b01;
            end
            check("req_ready", 32'(req_ready), 32'(m_rdy));
            check("busy", 32'(busy), 32'(m_busy));
            check("res_valid", 32'(res_valid), 32'(m_vld));
            if (m_busy) begin
                if (m_vld && res_ready) m_busy = 1'b0;
                else m_age++;
            end else if (m_rdy != 2'b00) begin
                m_item.id   = m_g;
                m_item.data = ref_product(req_x[m_g], req_y[m_g]);
`ifdef CSAM_MUL_ACC_EN
                if (req_acc[m_g]) m_acc[m_g] = m_acc[m_g] + m_item.data;
                else              m_acc[m_g] = m_item.data;
                m_item.data = m_acc[m_g];
`endif
                sb.push_back(m_item);
                m_last = m_g;
                m_busy = 1'b1;
                m_age  = 0;
            end
        end
    end

    // Monitor: every cycle a result is presented it must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got id %0d data %0h, expected none", res_id, res_data);
            end else begin
                check("res_id", 32'(res_id), 32'(sb[0].id));
                check("res_data", 32'(res_data), 32'(sb[0].data));
                if (res_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [7:0] x0, input logic [3:0] y0,
                           input logic [7:0] x1, input logic [3:0] y1, input logic [1:0] acc);
        req_valid = v;
        req_x     = {x1, x0};
        req_y     = {y1, y0};
        req_acc   = acc;
    endtask

    task automatic idle_req();
        set_req(2'b00, 8'd0, 4'd0, 8'd0, 4'd0, 2'b00);
    endtask

    initial begin
        rst_n     = 1'b0;
        res_ready = 1'b0;
        set_req(2'b11, 8'h12, 4'h3, 8'h45, 4'h6, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_id",    32'(res_id),    32'd0);
        check("rst_res_data",  32'(res_data),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);

        // Single request from requester 0: 3*5
        rst_n     = 1'b1;
        res_ready = 1'b1;
        set_req(2'b01, 8'h03, 4'h5, 8'h00, 4'h0, 2'b00);
        step();
        idle_req();
        repeat (3) step();

        // Both requesting from a fresh reset: grants alternate 0,1,0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_req(2'b11, 8'd2, 4'd3, 8'd4, 4'd2, 2'b00);
        repeat (9) step();
        idle_req();
        repeat (3) step();

        // Negative operand from requester 1: -3*5
        set_req(2'b10, 8'h00, 4'h0, 8'hFD, 4'h5, 2'b00);
        step();
        idle_req();
        repeat (3) step();

        // Back-pressure: result held, no new grants while stalled
        res_ready = 1'b0;
        set_req(2'b11, 8'h11, 4'h3, 8'h22, 4'hC, 2'b00);
        repeat (8) step();
        res_ready = 1'b1;
        repeat (6) step();
        idle_req();
        repeat (3) step();

        // Reset asserted while the multiply is in flight
        set_req(2'b01, 8'h05, 4'h5, 8'h00, 4'h0, 2'b00);
        step();
        rst_n = 1'b0;
        #1;
        check("midop_res_valid", 32'(res_valid), 32'd0);
        check("midop_busy",      32'(busy),      32'd0);
        check("midop_req_ready", 32'(req_ready), 32'd0);
        step();
        rst_n = 1'b1;
        set_req(2'b11, 8'd1, 4'd1, 8'd2, 4'd2, 2'b00);
        step();
        idle_req();
        repeat (3) step();

`ifdef CSAM_MUL_ACC_EN
        // Accumulation: load 21, add 10, then requester 1 accumulates from zero
        set_req(2'b01, 8'd7, 4'd3, 8'd0, 4'd0, 2'b00);
        step();
        idle_req();
        repeat (3) step();
        set_req(2'b01, 8'd2, 4'd5, 8'd0, 4'd0, 2'b01);
        step();
        idle_req();
        repeat (3) step();
        set_req(2'b10, 8'd0, 4'd0, 8'd1, 4'd1, 2'b10);
        step();
        idle_req();
        repeat (3) step();
`endif

        // Randomized traffic with back-pressure and occasional resets
        for (int i = 0; i < 600; i++) begin
            req_valid = 2'($urandom);
            req_x     = 16'($urandom);
            req_y     = 8'($urandom);
            req_acc   = 2'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 249) != 0);
            step();
        end

        rst_n     = 1'b1;
        res_ready = 1'b1;
        idle_req();
        repeat (6) step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending results, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
